ym3438_reg_sched: RTL and testbench

Slot-aligned register write scheduler for the OPN2 core. Accepts CPU-side register writes into a small in-order queue. Tracks the 24-slot operator sequence and releases each queued write on the first MCLK cycle of the slot that owns its target operator or channel. This keeps per-operator register updates coherent with the operator pipeline. It sits between the bus interface and the per-slot register shift memories, driven by the slot-sequencer strobes.

---
 rtl/ym3438_reg_sched.sv | 150 +++++++++++++++
 tb/tb_ym3438_reg_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ym3438_reg_sched.sv
// ============================================================================
// ym3438_reg_sched : slot-aligned register write scheduler for the OPN2 core.
// Optional tail coalescing enabled by defining YM3438_REG_SCHED_COALESCE_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ym3438_reg_sched #(
  parameter int DEPTH = 4
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       slot_tick,
  input  logic       slot_sync,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [2:0] wr_ch,
  input  logic [1:0] wr_op,
  input  logic [3:0] wr_reg,
  input  logic [7:0] wr_data,
  output logic       apply_en,
  output logic [4:0] apply_slot,
  output logic [3:0] apply_reg,
  output logic [7:0] apply_data,
  output logic       busy,
  output logic       locked,
  output logic       drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    slot_mem_q [DEPTH];
  logic [3:0]    reg_mem_q  [DEPTH];
  logic [7:0]    data_mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    slot_cnt_q, slot_cnt_d;
  logic          locked_q, arm_q;
  logic          apply_en_q, drop_q;
  logic [4:0]    apply_slot_q;
  logic [3:0]    apply_reg_q;
  logic [7:0]    apply_data_q;

  logic [2:0] ch_lin;
  logic [4:0] op_x6;
  logic [4:0] push_slot;
  logic       ch_ok, full, hs, pop, alloc, coalesce;

  // Linear channel index 0..5: bank selects the upper triple.
  assign ch_lin    = {1'b0, wr_ch[1:0]} + (wr_ch[2] ? 3'd3 : 3'd0);
  assign op_x6     = ({3'b000, wr_op} << 2) + ({3'b000, wr_op} << 1);
  assign push_slot = wr_reg[3] ? {2'b00, ch_lin} : (op_x6 + {2'b00, ch_lin});
  assign ch_ok     = (wr_ch[1:0] != 2'b11);
  assign full      = (count_q == FULL_CNT);
  assign hs        = wr_valid & wr_ready;
  assign pop       = arm_q & locked_q & (count_q != '0) &
                     (slot_mem_q[rd_ptr_q] == slot_cnt_q);

`ifdef YM3438_REG_SCHED_COALESCE_EN
  logic [AW-1:0] tail_ptr;
  logic          tail_match;

  assign tail_ptr   = wr_ptr_q - 1'b1;
  // A tail that is also the head being popped cannot absorb new data.
  assign tail_match = (count_q != '0) & ch_ok &
                      (slot_mem_q[tail_ptr] == push_slot) &
                      (reg_mem_q[tail_ptr] == wr_reg) &
                      ~(pop & (count_q == CW'(1)));
  assign wr_ready   = ~full | (wr_valid & tail_match);
  assign coalesce   = hs & tail_match;
  assign alloc      = hs & ch_ok & ~tail_match;
`else
  assign wr_ready   = ~full;
  assign coalesce   = 1'b0;
  assign alloc      = hs & ch_ok;
`endif

  always_comb begin
    slot_cnt_d = slot_cnt_q;
    if (slot_tick) begin
      if (slot_sync)               slot_cnt_d = 5'd0;
      else if (slot_cnt_q == 5'd23) slot_cnt_d = 5'd0;
      else                          slot_cnt_d = slot_cnt_q + 5'd1;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({alloc, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      slot_cnt_q   <= 5'd0;
      locked_q     <= 1'b0;
      arm_q        <= 1'b0;
      apply_en_q   <= 1'b0;
      apply_slot_q <= 5'd0;
      apply_reg_q  <= 4'd0;
      apply_data_q <= 8'd0;
      drop_q       <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      arm_q      <= slot_tick;
      count_q    <= count_d;
      drop_q     <= hs & ~ch_ok;
      apply_en_q <= pop;
      if (slot_tick & slot_sync) locked_q <= 1'b1;
      if (alloc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        apply_slot_q <= slot_mem_q[rd_ptr_q];
        apply_reg_q  <= reg_mem_q[rd_ptr_q];
        apply_data_q <= data_mem_q[rd_ptr_q];
      end
    end
  end

  // Queue storage carries no reset; occupancy alone qualifies entries.
  always_ff @(posedge MCLK) begin
    if (alloc) begin
      slot_mem_q[wr_ptr_q] <= push_slot;
      reg_mem_q[wr_ptr_q]  <= wr_reg;
      data_mem_q[wr_ptr_q] <= wr_data;
    end
`ifdef YM3438_REG_SCHED_COALESCE_EN
    if (coalesce) data_mem_q[tail_ptr] <= wr_data;
`endif
  end

  assign apply_en   = apply_en_q;
  assign apply_slot = apply_slot_q;
  assign apply_reg  = apply_reg_q;
  assign apply_data = apply_data_q;
  assign busy       = (count_q != '0);
  assign locked     = locked_q;
  assign drop       = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_ym3438_reg_sched.sv
// ============================================================================
// tb_ym3438_reg_sched : directed self-checking bench for ym3438_reg_sched.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ym3438_reg_sched;

  logic       MCLK = 1'b0;
  logic       reset = 1'b1;
  logic       slot_tick = 1'b0, slot_sync = 1'b0, wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_ch = 3'd0;
  logic [1:0] wr_op = 2'd0;
  logic [3:0] wr_reg = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       apply_en, busy, locked, drop;
  logic [4:0] apply_slot;
  logic [3:0] apply_reg;
  logic [7:0] apply_data;

  ym3438_reg_sched #(.DEPTH(4)) dut (
    .MCLK(MCLK), .reset(reset), .slot_tick(slot_tick), .slot_sync(slot_sync),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_op(wr_op),
    .wr_reg(wr_reg), .wr_data(wr_data), .apply_en(apply_en),
    .apply_slot(apply_slot), .apply_reg(apply_reg), .apply_data(apply_data),
    .busy(busy), .locked(locked), .drop(drop)
  );

  always #5 MCLK = ~MCLK;

  int ec = 0;
  always @(posedge MCLK) ec <= ec + 1;

  // Apply log captured mid-cycle.
  int         napp = 0;
  logic [4:0] a_slot [64];
  logic [3:0] a_reg  [64];
  logic [7:0] a_data [64];
  int         a_ec   [64];
  always @(negedge MCLK) begin
    if (apply_en === 1'b1) begin
      if (napp < 64) begin
        a_slot[napp] <= apply_slot;
        a_reg[napp]  <= apply_reg;
        a_data[napp] <= apply_data;
        a_ec[napp]   <= ec;
      end
      napp <= napp + 1;
    end
  end

  int tests = 0;
  int fails = 0;
  int tb_slot = 0;
  int tick_ec_at [24];
  int base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  task automatic tick(input logic sync);
    slot_tick = 1'b1;
    slot_sync = sync;
    step();
    if (sync) tb_slot = 0;
    else      tb_slot = (tb_slot == 23) ? 0 : tb_slot + 1;
    tick_ec_at[tb_slot] = ec;
    slot_tick = 1'b0;
    slot_sync = 1'b0;
    step();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic push(input logic [2:0] ch, input logic [1:0] op,
                      input logic [3:0] rg, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_op    = op;
    wr_reg   = rg;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tb_slot = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_locked", locked, 0);
    chk("rst_apply_en", apply_en, 0);
    chk("rst_apply_slot", apply_slot, 0);
    chk("rst_apply_data", apply_data, 0);
    chk("rst_drop", drop, 0);

    // Lock, then ch=1 op=2 operator reg -> slot 13.
    tick(1'b1);
    chk("lock_locked", locked, 1);
    base = napp;
    push(3'd1, 2'd2, 4'd2, 8'h5A);
    chk("lock_busy", busy, 1);
    ticks(24);
    step();
    chk("lock_count", napp - base, 1);
    chk("lock_slot", a_slot[base], 13);
    chk("lock_reg", a_reg[base], 2);
    chk("lock_data", a_data[base], 8'h5A);
    chk("lock_latency", a_ec[base], tick_ec_at[13] + 1);
    chk("lock_busy_end", busy, 0);

    // Invalid channel: acknowledged, dropped, never applied.
    base = napp;
    chk("inv_ready", wr_ready, 1);
    push(3'd3, 2'd0, 4'd0, 8'hEE);
    chk("inv_drop", drop, 1);
    chk("inv_busy", busy, 0);
    step();
    chk("inv_drop_end", drop, 0);
    ticks(24);
    step();
    chk("inv_no_apply", napp - base, 0);

    // Channel-wide register: ch=6 -> c=5, op ignored.
    base = napp;
    push(3'd6, 2'd3, 4'hA, 8'hC3);
    ticks(24);
    step();
    chk("chw_count", napp - base, 1);
    chk("chw_slot", a_slot[base], 5);
    chk("chw_reg", a_reg[base], 4'hA);
    chk("chw_data", a_data[base], 8'hC3);

    // Unlocked hold.
    do_reset();
    base = napp;
    push(3'd2, 2'd0, 4'd0, 8'h31);
    push(3'd4, 2'd1, 4'd0, 8'h32);
    push(3'd4, 2'd2, 4'd0, 8'h33);
    ticks(30);
    step();
    chk("unl_no_apply", napp - base, 0);
    chk("unl_busy", busy, 1);
    chk("unl_locked", locked, 0);
    tick(1'b1);
    ticks(23);
    step();
    chk("unl_count", napp - base, 3);
    chk("unl_slot0", a_slot[base], 2);
    chk("unl_slot1", a_slot[base + 1], 9);
    chk("unl_slot2", a_slot[base + 2], 15);
    chk("unl_data0", a_data[base], 8'h31);
    chk("unl_data2", a_data[base + 2], 8'h33);
    chk("unl_lat1", a_ec[base + 1], tick_ec_at[9] + 1);
    chk("unl_busy_end", busy, 0);

    // Full/backpressure: five writes to slot 23 (ch=6 op=3).
    do_reset();
    tick(1'b1);
    base = napp;
    for (int i = 0; i < 4; i++) push(3'd6, 2'd3, 4'd1, 8'hA0 + 8'(i));
    chk("full_ready", wr_ready, 0);
    ticks(22);
    chk("full_hold", wr_ready, 0);
    tick(1'b0);
    step();
    chk("full_first", napp - base, 1);
    chk("full_ready_pop", wr_ready, 1);
    push(3'd6, 2'd3, 4'd1, 8'hA4);
    ticks(96);
    step();
    chk("full_count", napp - base, 5);
    for (int i = 0; i < 5; i++) begin
      chk("full_data", a_data[base + i], 8'hA0 + 8'(i));
      chk("full_slot", a_slot[base + i], 23);
    end
    for (int i = 1; i < 4; i++) chk("full_spacing", a_ec[base + i + 1] - a_ec[base + i], 48);

    // Same target pushed back to back: slot 7 reg 1.
    do_reset();
    tick(1'b1);
    base = napp;
    push(3'd1, 2'd1, 4'd1, 8'h11);
    push(3'd1, 2'd1, 4'd1, 8'h22);
    ticks(48);
    step();
`ifdef YM3438_REG_SCHED_COALESCE_EN
    chk("coal_count", napp - base, 1);
    chk("coal_data", a_data[base], 8'h22);
    chk("coal_slot", a_slot[base], 7);
`else
    chk("dup_count", napp - base, 2);
    chk("dup_data0", a_data[base], 8'h11);
    chk("dup_data1", a_data[base + 1], 8'h22);
    chk("dup_spacing", a_ec[base + 1] - a_ec[base], 48);
`endif

    // Reset mid-queue discards everything.
    do_reset();
    tick(1'b1);
    base = napp;
    push(3'd4, 2'd0, 4'd0, 8'h41);
    push(3'd0, 2'd1, 4'd0, 8'h42);
    push(3'd5, 2'd3, 4'd0, 8'h43);
    chk("mid_busy_pre", busy, 1);
    do_reset();
    chk("mid_busy", busy, 0);
    chk("mid_locked", locked, 0);
    chk("mid_ready", wr_ready, 1);
    ticks(30);
    tick(1'b1);
    ticks(24);
    step();
    chk("mid_no_apply", napp - base, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
